// File: rtl/paddle_input.sv
// Player paddle controller: synchronises and debounces two raw push-buttons,
// detects the start of each vsync pulse, and once per frame moves the paddle
// up or down with a hold-to-accelerate speed ramp, clamped to the visible area.
module paddle_input #(
  parameter int V_RES            = 480,
  parameter int PADDLE_H         = 64,
  parameter int INIT_Y           = 208,
  parameter int DEB_CYCLES       = 252000,
  parameter int SPEED_MIN        = 2,
  parameter int SPEED_MAX        = 8,
  parameter int ACCEL_FRAMES     = 8,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       vsync,
  output logic [9:0] paddle_y,
  output logic       frame_tick,
  output logic       up_db,
  output logic       dn_db
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(SPEED_MAX + 1);
  localparam int AW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic            VS_IDLE  = (VSYNC_ACTIVE_LOW != 0);
  localparam logic [10:0]     Y_MAX    = 11'(V_RES - PADDLE_H);
  localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0]   SPD_MIN  = SW'(SPEED_MIN);
  localparam logic [SW-1:0]   SPD_MAX  = SW'(SPEED_MAX);
  localparam logic [AW-1:0]   ACC_LAST = AW'(ACCEL_FRAMES - 1);
  localparam logic [9:0]      Y_INIT   = 10'(INIT_Y);

  // ---------------------------------------------------------------------
  // Button conditioning: bit 0 = up, bit 1 = down
  // ---------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_db;

  assign btn_raw = {btn_dn, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          s1_reg;
      logic          s2_reg;
      logic          db_reg;
      logic [CW-1:0] cnt_reg;

      // Two-flop synchroniser followed by a run-length debouncer: the
      // accepted level only flips after DEB_CYCLES consecutive differing samples.
      always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          db_reg  <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= btn_raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            db_reg  <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign btn_db[gi] = db_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------
  logic vs_d_reg;
  logic frame_tick_reg;
  logic vs_act;
  logic vs_d_act;

  assign vs_act   = vsync ^ VS_IDLE;
  assign vs_d_act = vs_d_reg ^ VS_IDLE;

  // Registered inactive->active edge of vsync; one pulse per vsync pulse.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_reg       <= VS_IDLE;
      frame_tick_reg <= 1'b0;
    end else begin
      vs_d_reg       <= vsync;
      frame_tick_reg <= vs_act & ~vs_d_act;
    end
  end

  // ---------------------------------------------------------------------
  // Motion FSM
  // ---------------------------------------------------------------------
  typedef enum logic {ST_IDLE, ST_MOVE} state_t;

  state_t        state_reg, state_next;
  logic          dir_reg, dir_next;      // 1 = moving up
  logic [SW-1:0] speed_reg, speed_next;
  logic [AW-1:0] accel_reg, accel_next;
  logic [9:0]    y_reg, y_next;

  logic          one_btn;
  logic          step_en;
  logic [10:0]   y_wide;
  logic [10:0]   spd_wide;
  logic [10:0]   y_sum;
  logic [9:0]    y_up;
  logic [9:0]    y_dn;

  assign one_btn  = btn_db[0] ^ btn_db[1];
  assign y_wide   = {1'b0, y_reg};
  assign spd_wide = 11'(speed_reg);
  assign y_sum    = y_wide + spd_wide;
  // Saturating candidates; 11-bit maths keeps both limits wrap-free.
  assign y_up     = (y_wide < spd_wide) ? 10'd0 : 10'(y_wide - spd_wide);
  assign y_dn     = (y_sum > Y_MAX) ? 10'(Y_MAX) : 10'(y_sum);

  // State register for the motion FSM and paddle position.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      dir_reg   <= 1'b0;
      speed_reg <= SPD_MIN;
      accel_reg <= '0;
      y_reg     <= Y_INIT;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      speed_reg <= speed_next;
      accel_reg <= accel_next;
      y_reg     <= y_next;
    end
  end

  // Next-state logic, evaluated once per frame; a held button steps the
  // paddle and every ACCEL_FRAMES steps raise the speed for later frames.
  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    speed_next = speed_reg;
    accel_next = accel_reg;
    y_next     = y_reg;
    step_en    = 1'b0;
    if (frame_tick_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (one_btn) begin
            state_next = ST_MOVE;
            dir_next   = btn_db[0];
            step_en    = 1'b1;
          end else begin
            speed_next = SPD_MIN;
            accel_next = '0;
          end
        end
        ST_MOVE: begin
          if (one_btn && (btn_db[0] == dir_reg)) begin
            step_en = 1'b1;
          end else begin
            // Release, both pressed or reversal: stop for this frame.
            state_next = ST_IDLE;
            speed_next = SPD_MIN;
            accel_next = '0;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
      if (step_en) begin
        if (accel_reg == ACC_LAST) begin
          accel_next = '0;
          speed_next = (speed_reg < SPD_MAX) ? speed_reg + 1'b1 : SPD_MAX;
        end else begin
          accel_next = accel_reg + 1'b1;
        end
        y_next = btn_db[0] ? y_up : y_dn;
      end
    end
  end

  assign paddle_y   = y_reg;
  assign frame_tick = frame_tick_reg;
  assign up_db      = btn_db[0];
  assign dn_db      = btn_db[1];

endmodule

// File: tb/tb_paddle_input.sv
// Bench for paddle_input: a frame-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed paddle trajectories.
module tb_paddle_input;

  localparam int DEB   = 16;
  localparam int ACC   = 4;
  localparam int VPER  = 40;   // vsync period in cycles
  localparam int VLOW  = 3;    // vsync pulse width (active low)
  localparam int Y_LIM = 480 - 64;

  logic       clk_25 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       vsync  = 1'b1;
  logic [9:0] paddle_y;
  logic       frame_tick;
  logic       up_db;
  logic       dn_db;

  paddle_input #(
    .V_RES(480), .PADDLE_H(64), .INIT_Y(208), .DEB_CYCLES(DEB),
    .SPEED_MIN(2), .SPEED_MAX(8), .ACCEL_FRAMES(ACC), .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk_25(clk_25), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
    .vsync(vsync), .paddle_y(paddle_y), .frame_tick(frame_tick),
    .up_db(up_db), .dn_db(dn_db)
  );

  always #5 clk_25 = ~clk_25;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_s1_up, m_s2_up, m_s1_dn, m_s2_dn;
  int m_up, m_dn, m_run_up, m_run_dn;
  int m_vs_prev, m_tick, m_y, m_moving, m_dir, m_held;

  function automatic void model_reset();
    m_s1_up = 0; m_s2_up = 0; m_s1_dn = 0; m_s2_dn = 0;
    m_up = 0; m_dn = 0; m_run_up = 0; m_run_dn = 0;
    m_vs_prev = 1; m_tick = 0; m_y = 208;
    m_moving = 0; m_dir = 0; m_held = 0;
  endfunction

  function automatic void model_step();
    int spd;
    // Movement decided from last cycle's tick and debounced levels.
    if (m_tick != 0) begin
      if ((m_up ^ m_dn) != 0) begin
        if (m_moving != 0 && m_dir != m_up) begin
          m_moving = 0; m_held = 0;
        end else begin
          spd = 2 + m_held / ACC;
          if (spd > 8) spd = 8;
          if (m_up != 0) m_y = (m_y - spd < 0) ? 0 : m_y - spd;
          else           m_y = (m_y + spd > Y_LIM) ? Y_LIM : m_y + spd;
          m_held++; m_moving = 1; m_dir = m_up;
        end
      end else begin
        m_moving = 0; m_held = 0;
      end
    end
    // Debounce: flip after DEB consecutive samples that differ.
    if (m_s2_up != m_up) begin
      m_run_up++;
      if (m_run_up == DEB) begin m_up = m_s2_up; m_run_up = 0; end
    end else m_run_up = 0;
    if (m_s2_dn != m_dn) begin
      m_run_dn++;
      if (m_run_dn == DEB) begin m_dn = m_s2_dn; m_run_dn = 0; end
    end else m_run_dn = 0;
    // Frame tick: vsync falling edge, one cycle late.
    m_tick = (vsync == 1'b0 && m_vs_prev == 1) ? 1 : 0;
    m_vs_prev = int'(vsync);
    // Two-stage synchroniser delay.
    m_s2_up = m_s1_up; m_s1_up = int'(btn_up);
    m_s2_dn = m_s1_dn; m_s1_dn = int'(btn_dn);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk_25);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      check("paddle_y",   32'(paddle_y),   m_y);
      check("frame_tick", 32'(frame_tick), m_tick);
      check("up_db",      32'(up_db),      m_up);
      check("dn_db",      32'(dn_db),      m_dn);
    end
  end

  // ---------------- observers ----------------
  int         log_q[$];
  int         tick_cnt = 0;
  logic [9:0] last_y = 10'd208;

  initial begin
    forever begin
      @(posedge clk_25);
      #1;
      if (frame_tick === 1'b1) tick_cnt++;
      if (paddle_y !== last_y) begin
        log_q.push_back(int'(paddle_y));
        last_y = paddle_y;
      end
    end
  end

  // vsync source: VLOW-cycle low pulse every VPER cycles
  initial begin
    forever begin
      repeat (VPER - VLOW) @(negedge clk_25);
      vsync = 1'b0;
      repeat (VLOW) @(negedge clk_25);
      vsync = 1'b1;
    end
  end

  task automatic frames(input int n);
    repeat (n * VPER) @(negedge clk_25);
  endtask

  task automatic check_seq(input string name, input int exp[$], input bit exact);
    if (exact) check({name, "_len"}, 32'(log_q.size()), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < log_q.size()) check(name, 32'(log_q[i]), exp[i]);
      else                  check(name, 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_25);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_25);
    rst_n = 1'b1;
    log_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t0, lat, seen, mx;
    int e[$];

    repeat (3) @(negedge clk_25);
    rst_n = 1'b1;

    // 1: idle frames
    log_q.delete();
    t0 = tick_cnt;
    frames(3);
    check("idle_ticks", 32'(tick_cnt - t0), 3);
    check("idle_y", 32'(paddle_y), 208);
    check("idle_moves", 32'(log_q.size()), 0);

    // 2: glitch rejected, then debounce latency
    seen = 0;
    btn_up = 1'b1;
    repeat (10) begin @(negedge clk_25); seen |= int'(up_db); end
    btn_up = 1'b0;
    repeat (30) begin @(negedge clk_25); seen |= int'(up_db); end
    check("glitch_up_db", 32'(seen), 0);
    btn_up = 1'b1;
    lat = 0;
    while (up_db !== 1'b1 && lat < 100) begin @(negedge clk_25); lat++; end
    check("deb_latency", 32'(lat), 2 + DEB);
    frames(1);
    btn_up = 1'b0;
    frames(2);

    // 3: hold down from reset: ramp and clamp
    do_reset();
    btn_dn = 1'b1;
    frames(45);
    e = '{210, 212, 214, 216, 219, 222, 225, 228, 232};
    check_seq("ramp_dn", e, 1'b0);
    mx = 0;
    foreach (log_q[i]) if (log_q[i] > mx) mx = log_q[i];
    check("clamp_max", 32'(mx), 416);
    check("clamp_y", 32'(paddle_y), 416);
    btn_dn = 1'b0;
    frames(2);

    // 4: top limit, no wrap
    btn_up = 1'b1;
    frames(70);
    check("top_y", 32'(paddle_y), 0);
    btn_up = 1'b0;
    frames(2);
    log_q.delete();
    btn_dn = 1'b1; frames(5); btn_dn = 1'b0; frames(2);
    btn_up = 1'b1; frames(2); btn_up = 1'b0; frames(2);
    e = '{2, 4, 6, 8, 11, 9, 7};
    check_seq("to_seven", e, 1'b1);
    log_q.delete();
    btn_up = 1'b1; frames(6); btn_up = 1'b0; frames(2);
    e = '{5, 3, 1, 0};
    check_seq("top_clamp", e, 1'b1);
    check("top_hold", 32'(paddle_y), 0);

    // 5: both pressed = none, then down alone at minimum speed
    log_q.delete();
    btn_up = 1'b1; btn_dn = 1'b1;
    frames(4);
    check("both_moves", 32'(log_q.size()), 0);
    btn_up = 1'b0;
    frames(3);
    btn_dn = 1'b0;
    frames(2);
    e = '{2, 4, 6};
    check_seq("after_both", e, 1'b1);

    // 5b: direction reversal costs one frame, restarts at minimum speed
    log_q.delete();
    btn_dn = 1'b1; frames(3);
    btn_dn = 1'b0; btn_up = 1'b1; frames(3);
    btn_up = 1'b0; frames(2);
    e = '{8, 10, 12, 10, 8};
    check_seq("reversal", e, 1'b1);

    // 6: asynchronous reset mid-move
    btn_dn = 1'b1;
    frames(10);
    @(negedge clk_25);
    #2 rst_n = 1'b0;
    #1;
    check("async_y", 32'(paddle_y), 208);
    check("async_up_db", 32'(up_db), 0);
    check("async_dn_db", 32'(dn_db), 0);
    repeat (2) @(negedge clk_25);
    rst_n = 1'b1;
    log_q.delete();
    frames(3);
    e = '{210, 212};
    check_seq("post_reset", e, 1'b0);
    btn_dn = 1'b0;
    frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
